// File: rtl/usb_pkg.sv
// Shared types and constants for the USB token transmit path:
// FSM state encoding, field lengths, CRC5 polynomial/residual and PID codes.
package usb_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_PID   = 3'd2;
  localparam logic [2:0] S_FIELD = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SYNC  = S_SYNC,
    ST_PID   = S_PID,
    ST_FIELD = S_FIELD,
    ST_CRC   = S_CRC,
    ST_DONE  = S_DONE
  } tx_state_e;

  localparam logic [3:0] SYNC_LEN  = 4'd8;
  localparam logic [3:0] PID_LEN   = 4'd8;
  localparam logic [3:0] FIELD_LEN = 4'd11;
  localparam logic [3:0] CRC_LEN   = 4'd5;

  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_SOF   = 4'h5;

  // One serial step of CRC5 (x^5 + x^2 + 1), data bit entering at the MSB side.
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[4];
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

  // Counter value at which a transmitting state has sent its final bit.
  function automatic logic [3:0] state_last_idx(input tx_state_e st);
    case (st)
      ST_SYNC:  return SYNC_LEN - 4'd1;
      ST_PID:   return PID_LEN - 4'd1;
      ST_FIELD: return FIELD_LEN - 4'd1;
      ST_CRC:   return CRC_LEN - 4'd1;
      default:  return 4'd0;
    endcase
  endfunction

  // Packet section that follows a transmitting state.
  function automatic tx_state_e state_after(input tx_state_e st);
    case (st)
      ST_SYNC:  return ST_PID;
      ST_PID:   return ST_FIELD;
      ST_FIELD: return ST_CRC;
      ST_CRC:   return ST_DONE;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc5_gen.sv
// Serial CRC5 register. init presets it, shift advances it one bit: in data
// mode the bit is folded into the CRC, in output mode the register shifts left
// with a 1 fill so crc_bit walks out the inverted CRC, MSB first.
module usb_crc5_gen #(
  parameter logic [4:0] CRC_INIT = 5'h1F
) (
  input  logic clk_c,
  input  logic reset_n,
  input  logic init,
  input  logic shift,
  input  logic out_mode,
  input  logic din,
  output logic crc_bit
);
  import usb_pkg::*;

  logic [4:0] crc_r;
  logic [4:0] crc_nxt_s;

  // Next CRC value: preset, data fold, output shift or hold.
  always_comb begin
    crc_nxt_s = crc_r;
    if (init) begin
      crc_nxt_s = CRC_INIT;
    end else if (shift) begin
      if (out_mode) begin
        crc_nxt_s = {crc_r[3:0], 1'b1};
      end else begin
        crc_nxt_s = crc5_step(crc_r, din);
      end
    end else begin
      crc_nxt_s = crc_r;
    end
  end

  // CRC register, preset value on reset.
  always_ff @(posedge clk_c or negedge reset_n) begin
    if (!reset_n) begin
      crc_r <= CRC_INIT;
    end else begin
      crc_r <= crc_nxt_s;
    end
  end

  assign crc_bit = ~crc_r[4];

endmodule

// File: rtl/usb_token_tx.sv
// USB 2.0 token packet transmitter: SYNC, PID + check nibble, 11-bit field and
// inverted CRC5, NRZ, LSB first, stalled by halt_tx from the bit-stuffer.
// Optional SOF support is compiled in with `define SOF_FRAME_EN, which adds the
// sof_sel/frame_num ports and lets the field carry a frame number.
//
// The registered outputs always show the bit being offered this cycle; an
// unhalted cycle consumes it and loads the following bit. The CRC register is
// advanced as each field bit is loaded, so it is complete by the time the
// first CRC bit has to be loaded.
module usb_token_tx #(
  parameter logic [7:0] SYNC_PAT = 8'h80,
  parameter logic [4:0] CRC_INIT = 5'h1F
) (
  input  logic        clk_c,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  pid,
  input  logic [6:0]  addr,
  input  logic [3:0]  endp,
`ifdef SOF_FRAME_EN
  input  logic        sof_sel,
  input  logic [10:0] frame_num,
`endif
  input  logic        halt_tx,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);
  import usb_pkg::*;

  tx_state_e   state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [7:0]  pid_byte_r, pid_byte_nxt_s;
  logic [10:0] field_r, field_nxt_s, field_req_s;
  logic        bit_r, bit_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        last_r, last_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic        crc_init_s, crc_shift_s, crc_mode_s, crc_din_s, crc_bit_s;

  // Field word captured at start: frame number for SOF, else {endp, addr}.
  always_comb begin
`ifdef SOF_FRAME_EN
    if (sof_sel) begin
      field_req_s = frame_num;
    end else begin
      field_req_s = {endp, addr};
    end
`else
    field_req_s = {endp, addr};
`endif
  end

  // Next state, counter, latched fields, output bits and CRC controls.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    pid_byte_nxt_s = pid_byte_r;
    field_nxt_s    = field_r;
    bit_nxt_s      = bit_r;
    valid_nxt_s    = valid_r;
    last_nxt_s     = last_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = done_r;
    crc_init_s     = 1'b0;
    crc_shift_s    = 1'b0;
    crc_mode_s     = 1'b0;
    crc_din_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s    = ST_SYNC;
          cnt_nxt_s      = 4'd0;
          pid_byte_nxt_s = {~pid, pid};
          field_nxt_s    = field_req_s;
          crc_init_s     = 1'b1;
          bit_nxt_s      = SYNC_PAT[0];
          valid_nxt_s    = 1'b1;
          busy_nxt_s     = 1'b1;
          last_nxt_s     = 1'b0;
          done_nxt_s     = 1'b0;
        end else begin
          bit_nxt_s   = 1'b0;
          valid_nxt_s = 1'b0;
          busy_nxt_s  = 1'b0;
          last_nxt_s  = 1'b0;
          done_nxt_s  = 1'b0;
        end
      end
      ST_SYNC, ST_PID, ST_FIELD, ST_CRC: begin
        if (!halt_tx) begin
          if (cnt_r == state_last_idx(state_r)) begin
            state_nxt_s = state_after(state_r);
            cnt_nxt_s   = 4'd0;
          end else begin
            cnt_nxt_s   = cnt_r + 4'd1;
          end
          case (state_nxt_s)
            ST_SYNC:  bit_nxt_s = SYNC_PAT[cnt_nxt_s[2:0]];
            ST_PID:   bit_nxt_s = pid_byte_r[cnt_nxt_s[2:0]];
            ST_FIELD: begin
              bit_nxt_s   = field_r[cnt_nxt_s];
              crc_din_s   = field_r[cnt_nxt_s];
              crc_shift_s = 1'b1;
            end
            ST_CRC: begin
              bit_nxt_s   = crc_bit_s;
              crc_shift_s = 1'b1;
              crc_mode_s  = 1'b1;
            end
            default:  bit_nxt_s = 1'b0;
          endcase
          valid_nxt_s = (state_nxt_s != ST_DONE);
          busy_nxt_s  = (state_nxt_s != ST_DONE);
          done_nxt_s  = (state_nxt_s == ST_DONE);
          last_nxt_s  = (state_nxt_s == ST_CRC) && (cnt_nxt_s == CRC_LEN - 4'd1);
        end else begin
          state_nxt_s = state_r;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
        bit_nxt_s   = 1'b0;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        last_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
        bit_nxt_s   = 1'b0;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        last_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counter, latched packet fields and registered outputs.
  always_ff @(posedge clk_c or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      pid_byte_r <= 8'h00;
      field_r    <= 11'h000;
      bit_r      <= 1'b0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      pid_byte_r <= pid_byte_nxt_s;
      field_r    <= field_nxt_s;
      bit_r      <= bit_nxt_s;
      valid_r    <= valid_nxt_s;
      last_r     <= last_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  usb_crc5_gen #(
    .CRC_INIT (CRC_INIT)
  ) u_crc5 (
    .clk_c    (clk_c),
    .reset_n  (reset_n),
    .init     (crc_init_s),
    .shift    (crc_shift_s),
    .out_mode (crc_mode_s),
    .din      (crc_din_s),
    .crc_bit  (crc_bit_s)
  );

  // A halted cycle does not consume the offered bit, so it is not valid.
  assign tx_bit   = bit_r;
  assign tx_valid = valid_r & ~halt_tx;
  assign tx_last  = last_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: doc/usb_token_tx.md
Name: usb_token_tx

Overview:
- Serial transmitter for USB 2.0 token packets (IN/OUT/SETUP, optionally SOF).
- Latches PID, address and endpoint on a start pulse, then emits NRZ bits LSB-first in this order: SYNC, PID + check, 11-bit field, inverted CRC5.
- Sits directly upstream of the bit-stuffer/NRZI encoder.
- Honours that encoder's halt_tx stall; the downstream CRC5 checker validates the packet at the receive side.

Parameters:
- SYNC_PAT, 8'h80, SYNC byte sent LSB-first (NRZ 0000_0001).
- CRC_INIT, 5'h1F, CRC5 register preset at packet start.

Ports:
- clk_c  in  1  bit clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- pid  in  4  token PID[3:0]; check nibble generated as ~pid
- addr  in  7  device address
- endp  in  4  endpoint number
- halt_tx  in  1  active-high stall from bit-stuffer; freezes the block
- tx_bit  out  1  serial NRZ data bit
- tx_valid  out  1  tx_bit is valid this cycle
- tx_last  out  1  high with the final CRC bit
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last bit

Behaviour:
- Reset:
  - Asynchronous on reset_n low; acts immediately, including mid-packet.
  - State = IDLE; all outputs 0; CRC register = CRC_INIT; bit counter = 0.
  - Packet is abandoned. No done pulse.
- Outputs are registered. A start accepted in cycle N produces the first SYNC bit at cycle N+1 with tx_valid = 1.
- All fields are latched at start. Later changes to pid/addr/endp do not affect the packet in flight.
- FSM: IDLE -> SYNC(8 bits) -> PID(8) -> FIELD(11) -> CRC(5) -> DONE(1 cycle) -> IDLE.
  - A 4-bit bit counter runs within each state. Each state exits when the counter reaches its length-1 on an unhalted cycle.
- Bit order:
  - PID state: pid[0..3], then ~pid[0..3].
  - FIELD state: addr[0..6], then endp[0..3].
  - CRC state: ~crc[4] first, down to ~crc[0].
- CRC5:
  - Polynomial x^5+x^2+1, serial.
  - Preset to CRC_INIT on entering SYNC.
  - Updates only on FIELD bits: fb = bit ^ crc[4]; crc = {crc[3:0],0} ^ (fb ? 5'b00101 : 0).
  - In CRC state the register shifts left with a 1 fill.
- halt_tx high:
  - State, counter, CRC and tx_bit all hold; tx_valid = 0.
  - Takes effect the same cycle, combinationally gating the next-state enable.
  - halt_tx in IDLE or DONE has no effect.
- tx_last = 1 together with the 5th CRC bit. done = 1 in DONE; busy = 0 in DONE.
- A packet is exactly 32 valid bits spread over 32 + (number of halted cycles) cycles.
- start while busy is ignored. start in the DONE cycle is ignored (one idle cycle minimum between packets).

Optional Feature:
- Macro SOF_FRAME_EN.
- When defined:
  - Adds ports sof_sel (in, 1) and frame_num (in, 11).
  - If sof_sel = 1 at start, the FIELD state sends frame_num[0..10] instead of {endp,addr]; CRC5 covers frame_num.
  - pid is still taken from the pid port.
- When undefined: the ports are absent and FIELD is always {endp,addr}.

Decomposition:
- Package usb_pkg holds:
  - state encoding localparams (IDLE, SYNC, PID, FIELD, CRC, DONE);
  - field lengths (8, 8, 11, 5);
  - CRC5_POLY = 5'b00101;
  - CRC5_RESIDUAL = 5'b01100;
  - PID constants (OUT = 4'h1, IN = 4'h9, SETUP = 4'hD, SOF = 4'h5).
- Natural sub-module: usb_crc5_gen, a serial CRC5 register with init/shift/output-mode controls, reusable by the receive path.

Test Plan:
- SETUP, addr = 0, endp = 0, no halts -> 32 consecutive valid bits: 0000_0001, 1011_0100, eleven 0s, CRC bits 01000 (CRC5 = 0x02). tx_last on bit 32, done the next cycle.
- SETUP, addr = 7'h15, endp = 4'hE -> CRC field equals CRC5 = 0x17. Feeding the FIELD+CRC bits into a serial checker leaves residual 5'b01100.
- Same packet with halt_tx pseudo-random at 30% -> identical bit sequence on tx_valid cycles. tx_bit is stable during halts. Total cycles = 32 + number of halts.
- start re-pulsed at bits 5 and 20, and in the DONE cycle -> ignored. Changing addr mid-packet has no effect on the output.
- reset_n low during the FIELD state -> outputs go 0 immediately, no done pulse. A new start after release sends a full, correct packet.
- SOF_FRAME_EN, sof_sel = 1, pid = 4'h5, frame_num = 11'h710 -> FIELD carries frame_num LSB-first. The CRC checker residual is 5'b01100.
